// File: rtl/z80_io_initiator_pkg.sv
// Shared definitions for the Z80-style I/O initiator and its mailbox peer.
//  - Mailbox register map (base address and register offsets).
//  - FSM state encoding for the initiator bus cycle.
//  - Latched request record used for the duration of one bus cycle.
package z80_io_initiator_pkg;

  localparam logic [7:0] MAILBOX_BASE = 8'h80;
  localparam logic [7:0] DATA_OFS     = 8'h00;
  localparam logic [7:0] STATUS_OFS   = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  typedef struct packed {
    logic       write;
    logic [7:0] addr;
    logic [7:0] wdata;
  } io_req_t;

endpackage

// File: rtl/z80_io_initiator_timer.sv
// z80_phase_timer: loadable down-counter that times each bus phase.
//  clk       in  clock
//  reset     in  synchronous active-high reset (count -> 0)
//  load      in  reload the counter with load_val this cycle
//  load_val  in  CNT_W reload value (phase length minus one)
//  zero      out counter is 0 (last cycle of the current phase)
// The counter decrements while nonzero and parks at 0; it never wraps,
// so a phase stretched by wait just sits at zero.
module z80_phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)              cnt_d = load_val;
    else if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/z80_io_initiator.sv
// z80_io_initiator: Z80-style I/O bus master. Turns single-beat valid/ready
// requests into timed OUT (write) / IN (read) bus cycles with active-low
// strobes and returns a one-cycle response at the end of every cycle.
//
// Optional feature macro: Z80_WAIT_EN (adds z80_wait_b; strobe is stretched
// while the registered wait input is low at the end of the strobe phase).
//
// Ports
//  clk, reset                 clock, synchronous active-high reset
//  req_valid/req_ready        request handshake (ready only in IDLE)
//  req_write/req_addr/wdata   1=OUT 0=IN, 8-bit port address, write data
//  rsp_valid/rsp_rdata        end-of-cycle pulse; read data (0 after write)
//  z80_address_bus            address, held between cycles
//  z80_data_bus_out/_oe       write data and its drive enable
//  z80_data_bus_in            read data from the responder
//  z80_write_strobe_b         active-low write strobe
//  z80_read_strobe_b          active-low read strobe
//  z80_wait_b                 active-low wait (Z80_WAIT_EN only)
module z80_io_initiator
  import z80_io_initiator_pkg::*;
#(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 2,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [7:0] z80_address_bus,
  output logic [7:0] z80_data_bus_out,
  output logic       z80_data_bus_oe,
  input  logic [7:0] z80_data_bus_in,
  output logic       z80_write_strobe_b,
  output logic       z80_read_strobe_b
`ifdef Z80_WAIT_EN
  ,
  input  logic       z80_wait_b
`endif
);

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  io_req_t          req_q, req_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             oe_q, oe_d;
  logic             wr_b_q, wr_b_d;
  logic             rd_b_q, rd_b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             ready_q, ready_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;
  logic             accept;
  logic             strobe_done;

  assign accept = ready_q && req_valid;

`ifdef Z80_WAIT_EN
  // Wait is flopped once before use; the responder must pull it low within
  // STROBE_CYCLES-1 clocks of strobe fall for it to be seen at count 0.
  logic wait_b_q;
  always_ff @(posedge clk) begin
    if (reset) wait_b_q <= 1'b1;
    else       wait_b_q <= z80_wait_b;
  end
  assign strobe_done = tmr_zero && wait_b_q;
`else
  assign strobe_done = tmr_zero;
`endif

  z80_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // State register and all output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      rdata_q     <= 8'h00;
      oe_q        <= 1'b0;
      wr_b_q      <= 1'b1;
      rd_b_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      rdata_q     <= rdata_d;
      oe_q        <= oe_d;
      wr_b_q      <= wr_b_d;
      rd_b_q      <= rd_b_d;
      rsp_valid_q <= rsp_valid_d;
      ready_q     <= ready_d;
    end
  end

  // Next state and phase-timer reload (every phase entry reloads)
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_IDLE: if (accept) begin
        state_d  = ST_SETUP;
        tmr_load = 1'b1;
        tmr_val  = SETUP_LD;
      end
      ST_SETUP: if (tmr_zero) begin
        state_d  = ST_STROBE;
        tmr_load = 1'b1;
        tmr_val  = STROBE_LD;
      end
      ST_STROBE: if (strobe_done) begin
        state_d  = ST_HOLD;
        tmr_load = 1'b1;
        tmr_val  = HOLD_LD;
      end
      ST_HOLD: if (tmr_zero) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output register next values
  always_comb begin
    req_d       = req_q;
    rdata_d     = rdata_q;
    oe_d        = oe_q;
    wr_b_d      = wr_b_q;
    rd_b_d      = rd_b_q;
    rsp_valid_d = 1'b0;
    ready_d     = (state_d == ST_IDLE);
    case (state_q)
      ST_IDLE: if (accept) begin
        req_d.write = req_write;
        req_d.addr  = req_addr;
        req_d.wdata = req_wdata;
        oe_d        = req_write;
      end
      ST_SETUP: if (tmr_zero) begin
        // Exactly one strobe falls, chosen by the latched request type
        wr_b_d = ~req_q.write;
        rd_b_d = req_q.write;
      end
      ST_STROBE: if (strobe_done) begin
        wr_b_d  = 1'b1;
        rd_b_d  = 1'b1;
        rdata_d = req_q.write ? 8'h00 : z80_data_bus_in;
      end
      ST_HOLD: if (tmr_zero) begin
        oe_d        = 1'b0;
        rsp_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign req_ready          = ready_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_rdata          = rdata_q;
  assign z80_address_bus    = req_q.addr;
  assign z80_data_bus_out   = req_q.wdata;
  assign z80_data_bus_oe    = oe_q;
  assign z80_write_strobe_b = wr_b_q;
  assign z80_read_strobe_b  = rd_b_q;

endmodule

// File: tb/tb_z80_io_initiator.sv
`timescale 1ns/1ps
module tb_z80_io_initiator;
  import z80_io_initiator_pkg::*;

  localparam logic [7:0] A_DATA = MAILBOX_BASE + DATA_OFS;
  localparam logic [7:0] A_STAT = MAILBOX_BASE + STATUS_OFS;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // Instance A: default timing
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata, abus, dout, din;
  logic       oe, wr_b, rd_b;
`ifdef Z80_WAIT_EN
  logic       wait_b = 1'b1;
`endif

  z80_io_initiator dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .z80_address_bus(abus), .z80_data_bus_out(dout), .z80_data_bus_oe(oe),
    .z80_data_bus_in(din), .z80_write_strobe_b(wr_b), .z80_read_strobe_b(rd_b)
`ifdef Z80_WAIT_EN
    , .z80_wait_b(wait_b)
`endif
  );

  // Instance B: STROBE_CYCLES=3, HOLD_CYCLES=1
  logic       b_req_valid, b_req_ready, b_req_write;
  logic [7:0] b_req_addr, b_req_wdata;
  logic       b_rsp_valid;
  logic [7:0] b_rsp_rdata, b_abus, b_dout, b_din;
  logic       b_oe, b_wr_b, b_rd_b;

  z80_io_initiator #(.SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(1)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .z80_address_bus(b_abus), .z80_data_bus_out(b_dout), .z80_data_bus_oe(b_oe),
    .z80_data_bus_in(b_din), .z80_write_strobe_b(b_wr_b), .z80_read_strobe_b(b_rd_b)
`ifdef Z80_WAIT_EN
    , .z80_wait_b(wait_b)
`endif
  );

  // Mailbox responder models with a 2-flop read path
  logic [7:0] mb_dout, mb_stat, mb_din, rd_val, rd_p1, rd_p2;
  logic [7:0] b_rd_p1, b_rd_p2;
  always_comb rd_val = (abus == A_DATA) ? mb_din : (abus == A_STAT) ? mb_stat : 8'hFF;
  always @(posedge clk) begin
    if (reset) begin
      mb_dout <= 8'h00; mb_stat <= 8'h00; rd_p1 <= 8'h00; rd_p2 <= 8'h00;
      b_rd_p1 <= 8'h00; b_rd_p2 <= 8'h00;
    end else begin
      if (!wr_b && oe) begin
        if (abus == A_DATA)      mb_dout <= dout;
        else if (abus == A_STAT) mb_stat <= dout;
      end
      rd_p1   <= rd_b ? 8'h00 : rd_val;
      rd_p2   <= rd_p1;
      b_rd_p1 <= b_rd_b ? 8'h00 : ((b_abus == A_STAT) ? 8'h5A : 8'hFF);
      b_rd_p2 <= b_rd_p1;
    end
  end
  assign din   = rd_p2;
  assign b_din = b_rd_p2;

  int errors = 0;
  int checks = 0;
  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] rdata; int acc; } sb_t;
  sb_t sb[$];

  // Monitor for instance A: scoreboard, strobe overlap, widths, oe time
  int wr_run = 0, rd_run = 0, wr_w = 0, rd_w = 0, oe_total = 0;
  always @(negedge clk) begin
    sb_t e;
    if (!reset) chk("no_strobe_overlap", int'(!wr_b && !rd_b), 0);
    if (oe === 1'b1) oe_total++;
    if (wr_b === 1'b0) wr_run++;
    else if (wr_run != 0) begin wr_w = wr_run; wr_run = 0; end
    if (rd_b === 1'b0) rd_run++;
    else if (rd_run != 0) begin rd_w = rd_run; rd_run = 0; end
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_rsp", 1, 0);
      else begin
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_latency", cyc - e.acc, 9);
      end
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic send(input bit w, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] e, output int acc);
    sb_t t;
    acc = -1000;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    for (int i = 0; i < 60; i++) begin
      if (req_ready) begin
        t.rdata = e; t.acc = cyc; acc = cyc;
        sb.push_back(t);
        step();
        return;
      end
      step();
    end
    chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 80; i++) begin
      if (sb.size() == 0) return;
      step();
    end
    chk("rsp_timeout", int'(sb.size()), 0);
    sb.delete();
  endtask

  typedef struct { bit w; logic [7:0] a; logic [7:0] d; logic [7:0] e; } vec_t;
  vec_t vecs[8];

  initial begin
    int a1, a2, o0, n, ba;
    bit got;
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a1, a2, o0, n, ba;
    bit got;
    vecs[0] = '{1'b1, A_DATA, 8'h5A, 8'h00};
    vecs[1] = '{1'b0, A_DATA, 8'h00, 8'h3C};
    vecs[2] = '{1'b1, A_STAT, 8'hC3, 8'h00};
    vecs[3] = '{1'b0, A_STAT, 8'h00, 8'hC3};
    vecs[4] = '{1'b0, 8'h42,  8'h00, 8'hFF};
    vecs[5] = '{1'b1, A_STAT, 8'h00, 8'h00};
    vecs[6] = '{1'b0, A_STAT, 8'hEE, 8'h00};
    vecs[7] = '{1'b0, A_DATA, 8'h00, 8'h3C};

    mb_din = 8'h3C;
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 8'h00; b_req_wdata = 8'h00;
    repeat (3) step();

    // Reset state
    chk("rst_wr_b", wr_b, 1);
    chk("rst_rd_b", rd_b, 1);
    chk("rst_oe", oe, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_addr", abus, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ready", req_ready, 1);
    reset = 1'b0;
    step();

    // 1. write 80/A5
    o0 = oe_total;
    send(1'b1, A_DATA, 8'hA5, 8'h00, a1);
    req_valid = 1'b0;
    wait_idle();
    chk("t1_wr_width", wr_w, 4);
    chk("t1_oe_cycles", oe_total - o0, 8);
    chk("t1_mb_dout", mb_dout, 8'hA5);
    chk("t1_idle_addr", abus, A_DATA);
    chk("t1_idle_dout", dout, 8'hA5);
    chk("t1_idle_oe", oe, 0);

    // 2. read 80 -> 3C
    o0 = oe_total;
    send(1'b0, A_DATA, 8'h99, 8'h3C, a1);
    req_valid = 1'b0;
    wait_idle();
    chk("t2_rd_width", rd_w, 4);
    chk("t2_oe_never", oe_total - o0, 0);

    // 3. back-to-back write then read with req_valid held
    send(1'b1, A_STAT, 8'h01, 8'h00, a1);
    send(1'b0, A_STAT, 8'h00, 8'h01, a2);
    req_valid = 1'b0;
    wait_idle();
    chk("t3_b2b_accept_gap", a2 - a1, 9);

    // 4. reset in the middle of a write strobe
    send(1'b1, A_DATA, 8'h77, 8'h00, a1);
    req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!wr_b) break;
      step();
    end
    chk("t4_in_strobe", wr_b, 0);
    step();
    reset = 1'b1;
    sb.delete();
    step();
    chk("t4_wr_b", wr_b, 1);
    chk("t4_rd_b", rd_b, 1);
    chk("t4_oe", oe, 0);
    chk("t4_rsp_valid", rsp_valid, 0);
    chk("t4_ready", req_ready, 1);
    reset = 1'b0;
    step();
    send(1'b1, A_DATA, 8'h66, 8'h00, a1);
    req_valid = 1'b0;
    wait_idle();
    chk("t4_after_mb_dout", mb_dout, 8'h66);

    // Vector table, applied back-to-back
    foreach (vecs[k]) send(vecs[k].w, vecs[k].a, vecs[k].d, vecs[k].e, a1);
    req_valid = 1'b0;
    wait_idle();
    chk("tbl_mb_dout", mb_dout, 8'h5A);
    chk("tbl_mb_stat", mb_stat, 8'h00);

    // 6. short timing instance: read status
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = A_STAT;
    chk("b_ready", b_req_ready, 1);
    ba = cyc;
    step();
    b_req_valid = 1'b0;
    n = 0; got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (b_rsp_valid) begin got = 1'b1; break; end
      if (!b_rd_b) n++;
      step();
    end
    chk("b_rsp_seen", int'(got), 1);
    chk("b_latency", cyc - ba, 7);
    chk("b_rdata", b_rsp_rdata, 8'h5A);
    chk("b_rd_width", n, 3);
    step();
    chk("b_rsp_pulse", b_rsp_valid, 0);

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
